// File: rtl/ps2_command_tx.sv
// Host-to-device PS/2 command transmitter: inhibits the bus, issues a request-to-send,
// shifts one byte plus odd parity and stop out on device clock falls, then checks the ACK.
module ps2_command_tx #(
  parameter int CLOCK_FREQUENCY    = 25000000,
  parameter int INHIBIT_CYCLES     = 3000,
  parameter int REQ_TIMEOUT_CYCLES = 375000,
  parameter int BIT_TIMEOUT_CYCLES = 50000
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic [7:0] cmd_data,
  input  logic       cmd_send,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic [2:0] dbg_state
);

  localparam int CW = $clog2(REQ_TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] REQ_LAST = CW'(REQ_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INHIBIT = 3'd1,
    REQ     = 3'd2,
    SEND    = 3'd3,
    ACK     = 3'd4,
    RELEASE = 3'd5,
    DONE    = 3'd6,
    FAIL    = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [10:0]   sr_q, sr_d;
  logic          clk_s1_q, clk_s2_q, clk_prev_q;
  logic          dat_s1_q, dat_s2_q;
  logic          clk_oe_q, clk_oe_d;
  logic          dat_oe_q, dat_oe_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          tx_done_q, tx_done_d;
  logic          tx_error_q, tx_error_d;
  logic          fall;

  // Falls are taken from the synchronised line so a device edge is seen exactly once.
  assign fall = clk_prev_q & ~clk_s2_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    sr_d     = sr_q;
    dat_oe_d = dat_oe_q;

    case (state_q)
      IDLE: begin
        if (cmd_send) begin
          sr_d     = {1'b1, ~^cmd_data, cmd_data};
          cnt_d    = '0;
          bitcnt_d = '0;
          state_d  = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d    = '0;
          dat_oe_d = 1'b1;
          state_d  = REQ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REQ: begin
        if (fall) begin
          dat_oe_d = ~sr_q[0];
          sr_d     = {1'b1, sr_q[10:1]};
          bitcnt_d = 4'd1;
          cnt_d    = '0;
          state_d  = SEND;
        end else if (cnt_q == REQ_LAST) begin
          state_d = FAIL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SEND: begin
        if (fall) begin
          dat_oe_d = ~sr_q[0];
          sr_d     = {1'b1, sr_q[10:1]};
          bitcnt_d = bitcnt_q + 4'd1;
          cnt_d    = '0;
          if (bitcnt_q == 4'd9) state_d = ACK;
        end else if (cnt_q == BIT_LAST) begin
          state_d = FAIL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACK: begin
        if (fall) begin
          cnt_d   = '0;
          state_d = dat_s2_q ? FAIL : RELEASE;
        end else if (cnt_q == BIT_LAST) begin
          state_d = FAIL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        if (clk_s2_q && dat_s2_q) begin
          state_d = DONE;
        end else if (cnt_q == BIT_LAST) begin
          state_d = FAIL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Data is only ever pulled while the start bit or a data/parity bit is on the wire.
    if (state_d != REQ && state_d != SEND) dat_oe_d = 1'b0;
    clk_oe_d    = (state_d == INHIBIT);
    cmd_ready_d = (state_d == IDLE);
    tx_done_d   = (state_d == DONE);
    tx_error_d  = (state_d == FAIL);
  end

  always_ff @(posedge Clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bitcnt_q    <= '0;
      sr_q        <= '0;
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      clk_prev_q  <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      clk_oe_q    <= 1'b0;
      dat_oe_q    <= 1'b0;
      cmd_ready_q <= 1'b1;
      tx_done_q   <= 1'b0;
      tx_error_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitcnt_q    <= bitcnt_d;
      sr_q        <= sr_d;
      clk_s1_q    <= ps2_clk_in;
      clk_s2_q    <= clk_s1_q;
      clk_prev_q  <= clk_s2_q;
      dat_s1_q    <= ps2_dat_in;
      dat_s2_q    <= dat_s1_q;
      clk_oe_q    <= clk_oe_d;
      dat_oe_q    <= dat_oe_d;
      cmd_ready_q <= cmd_ready_d;
      tx_done_q   <= tx_done_d;
      tx_error_q  <= tx_error_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign tx_busy    = ~cmd_ready_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign tx_done    = tx_done_q;
  assign tx_error   = tx_error_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ps2_command_tx.sv
// Directed bench for ps2_command_tx with a behavioural keyboard on the open-drain lines.
module tb_ps2_command_tx;

  localparam int INH = 300;
  localparam int REQ_T = 2000;
  localparam int BIT_T = 500;
  localparam int H = 50;  // device clock half period in system cycles

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_send = 1'b0;
  logic       cmd_ready, ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done, tx_error;
  logic [2:0] dbg_state;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       clk_line, dat_line;

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int overlap_cnt = 0;

  assign clk_line = ~ps2_clk_oe & dev_clk;
  assign dat_line = ~ps2_dat_oe & dev_dat;

  ps2_command_tx #(
    .CLOCK_FREQUENCY(25000000),
    .INHIBIT_CYCLES(INH),
    .REQ_TIMEOUT_CYCLES(REQ_T),
    .BIT_TIMEOUT_CYCLES(BIT_T)
  ) dut (
    .Clock(clk),
    .reset(reset),
    .cmd_data(cmd_data),
    .cmd_send(cmd_send),
    .cmd_ready(cmd_ready),
    .ps2_clk_in(clk_line),
    .ps2_dat_in(dat_line),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .tx_error(tx_error),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_done === 1'b1) done_cnt++;
    if (tx_error === 1'b1) err_cnt++;
    if (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b1) overlap_cnt++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues a command, measures the inhibit period and confirms the start bit.
  task automatic send_and_inhibit(input logic [7:0] b, input bit poke_busy);
    int n;
    cmd_data = b;
    cmd_send = 1'b1;
    step(1);
    cmd_send = 1'b0;
    check("accept_clk_oe", {31'd0, ps2_clk_oe}, 32'd1);
    check("accept_busy", {31'd0, tx_busy}, 32'd1);
    n = 1;
    while (ps2_clk_oe === 1'b1 && n < INH + 50) begin
      if (poke_busy && n == 10) begin
        cmd_send = 1'b1;
        cmd_data = 8'h00;
      end
      step(1);
      cmd_send = 1'b0;
      if (ps2_clk_oe === 1'b1) n++;
    end
    check("inhibit_len", n, INH);
    check("start_dat_oe", {31'd0, ps2_dat_oe}, 32'd1);
    check("start_line", {31'd0, dat_line}, 32'd0);
  endtask

  task automatic dev_pulse(output logic seen);
    dev_clk = 1'b0;
    step(H);
    dev_clk = 1'b1;
    seen = dat_line;
    step(H);
  endtask

  task automatic dev_frame(input int nfalls, output logic [9:0] bits);
    logic b;
    bits = '0;
    step(20);
    for (int i = 0; i < nfalls && i < 10; i++) begin
      dev_pulse(b);
      bits[i] = b;
    end
  endtask

  task automatic dev_ack(input bit ack_low);
    dev_dat = ack_low ? 1'b0 : 1'b1;
    dev_clk = 1'b0;
    step(H);
    dev_clk = 1'b1;
    step(H);
    dev_dat = 1'b1;
  endtask

  task automatic wait_pulse(input string tag, input bit want_err, input int bound);
    int n = 0;
    while (((want_err ? tx_error : tx_done) !== 1'b1) && n < bound) begin
      step(1);
      n++;
    end
    check(tag, {31'd0, (want_err ? tx_error : tx_done)}, 32'd1);
  endtask

  initial begin
    logic [9:0] bits;
    int d0, e0, n;

    // Reset values
    step(3);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    check("rst_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
    check("rst_done", {31'd0, tx_done}, 32'd0);
    check("rst_error", {31'd0, tx_error}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    reset = 1'b0;
    step(2);

    // 0xED: d0..d7 = 1,0,1,1,0,1,1,1 ; parity 1 ; stop 1
    d0 = done_cnt; e0 = err_cnt;
    send_and_inhibit(8'hED, 1'b0);
    dev_frame(10, bits);
    check("ed_bits", {22'd0, bits}, 32'h3ED);
    dev_ack(1'b1);
    wait_pulse("ed_done", 1'b0, 100);
    step(1);
    check("ed_done_width", {31'd0, tx_done}, 32'd0);
    check("ed_ready", {31'd0, cmd_ready}, 32'd1);
    check("ed_done_cnt", done_cnt - d0, 1);
    check("ed_err_cnt", err_cnt - e0, 0);

    // 0xF4: parity 0, with a second request poked in during inhibit
    d0 = done_cnt; e0 = err_cnt;
    send_and_inhibit(8'hF4, 1'b1);
    dev_frame(10, bits);
    check("f4_bits", {22'd0, bits}, 32'h2F4);
    dev_ack(1'b1);
    wait_pulse("f4_done", 1'b0, 100);
    step(2);
    check("f4_done_cnt", done_cnt - d0, 1);
    check("f4_err_cnt", err_cnt - e0, 0);
    check("f4_idle_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);

    // 0x00: parity 1; cmd_send during the DONE cycle must be dropped
    d0 = done_cnt; e0 = err_cnt;
    send_and_inhibit(8'h00, 1'b0);
    dev_frame(10, bits);
    check("00_bits", {22'd0, bits}, 32'h300);
    dev_ack(1'b1);
    wait_pulse("00_done", 1'b0, 100);
    cmd_data = 8'hFF;
    cmd_send = 1'b1;
    step(1);
    cmd_send = 1'b0;
    check("retry_ready", {31'd0, cmd_ready}, 32'd1);
    step(1);
    check("retry_ignored", {31'd0, ps2_clk_oe}, 32'd0);
    check("retry_busy", {31'd0, tx_busy}, 32'd0);
    check("00_done_cnt", done_cnt - d0, 1);
    check("00_err_cnt", err_cnt - e0, 0);

    // Request timeout: device never clocks
    d0 = done_cnt; e0 = err_cnt;
    send_and_inhibit(8'hF4, 1'b0);
    n = 0;
    while (tx_error !== 1'b1 && n < REQ_T + 100) begin
      step(1);
      n++;
    end
    check("req_timeout_len", n, REQ_T);
    check("req_to_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    check("req_to_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
    step(1);
    check("req_to_ready", {31'd0, cmd_ready}, 32'd1);
    check("req_to_err_width", {31'd0, tx_error}, 32'd0);
    check("req_to_done_cnt", done_cnt - d0, 0);

    // Bit timeout after fall 5; error lands BIT_T cycles after the synchronised fall (3 flops later)
    d0 = done_cnt; e0 = err_cnt;
    send_and_inhibit(8'hED, 1'b0);
    dev_frame(4, bits);
    dev_clk = 1'b0;
    n = 0;
    while (tx_error !== 1'b1 && n < BIT_T + 200) begin
      step(1);
      n++;
      if (n == H) dev_clk = 1'b1;
    end
    check("bit_timeout_len", n, BIT_T + 3);
    step(2);
    check("bit_to_err_cnt", err_cnt - e0, 1);
    check("bit_to_done_cnt", done_cnt - d0, 0);
    check("bit_to_ready", {31'd0, cmd_ready}, 32'd1);

    // Missing ACK: DAT left high on fall 11
    d0 = done_cnt; e0 = err_cnt;
    send_and_inhibit(8'hED, 1'b0);
    dev_frame(10, bits);
    dev_ack(1'b0);
    step(5);
    check("nack_err_cnt", err_cnt - e0, 1);
    check("nack_done_cnt", done_cnt - d0, 0);
    check("nack_ready", {31'd0, cmd_ready}, 32'd1);

    // Reset during SEND after fall 4 (d3 of 0x00 keeps DAT pulled)
    d0 = done_cnt; e0 = err_cnt;
    send_and_inhibit(8'h00, 1'b0);
    dev_frame(4, bits);
    check("pre_rst_dat_oe", {31'd0, ps2_dat_oe}, 32'd1);
    reset = 1'b1;
    step(1);
    check("mid_rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    check("mid_rst_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
    check("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
    reset = 1'b0;
    step(5);
    check("mid_rst_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
    check("mid_rst_idle", {31'd0, tx_busy}, 32'd0);

    check("oe_overlap", overlap_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
